// File: rtl/dii_ring_station_if.sv
// DII flit channel: one flit (valid, last, data) plus a ready handshake.
// master drives valid/last/data and samples ready; slave does the reverse.
interface dii_ring_station_if;
    logic        valid;
    logic        last;
    logic [15:0] data;
    logic        ready;

    modport master (output valid, last, data, input ready);
    modport slave  (input valid, last, data, output ready);
endinterface

// File: rtl/dii_ring_station.sv
// DII ring station: delivers ring packets addressed to id to the local
// module, forwards the rest, and merges local packets onto the ring.
// Ports: clk, rst (sync, active high), id (station ID),
//   ring_in  (slave)  upstream ring flits, buffered in a FIFO
//   ring_out (master) registered downstream ring flits
//   local_in (slave)  local packets to inject
//   local_out(master) packets addressed to this station
module dii_ring_station #(
    parameter int BUFFER_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        id,
    dii_ring_station_if.slave  ring_in,
    dii_ring_station_if.master ring_out,
    dii_ring_station_if.slave  local_in,
    dii_ring_station_if.master local_out
);
    localparam int AW = $clog2(BUFFER_DEPTH);

    typedef enum logic [1:0] {IDLE, TO_LOCAL, TO_RING} state_t;
    state_t state, state_nxt;

    logic [16:0] mem [BUFFER_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;
    logic [16:0] head;
    logic        head_last, head_local;

    logic gnt_fwd, gnt_inj, last_inj;
    logic free, fwd_req, inj_req, tie, win_fwd, win_inj;
    logic load_ok, fwd_load, inj_load, lo_xfer;

    logic        out_valid;
    logic [16:0] out_flit;

    // ring input FIFO
    assign empty      = wr_ptr == rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_last  = head[16];
    assign head_local = head[15:0] == id;

    assign ring_in.ready = !rst && !full;
    assign push          = ring_in.valid && ring_in.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {ring_in.last, ring_in.data};
    end

    // ring_out arbiter; a fresh grant is combinational so an injected
    // header can transfer in the cycle it first appears
    always_comb begin
        free    = !gnt_fwd && !gnt_inj;
        fwd_req = (state == IDLE) && !empty && !head_local;
        inj_req = local_in.valid;
        tie     = free && fwd_req && inj_req;
        win_fwd = free && fwd_req && (!inj_req || last_inj);
        win_inj = free && inj_req && (!fwd_req || !last_inj);
    end

    assign load_ok        = !out_valid || ring_out.ready;
    assign local_in.ready = !rst && (gnt_inj || win_inj) && load_ok;
    assign inj_load       = local_in.valid && local_in.ready;

    // last_inj remembers the winner of the most recent contested
    // arbitration, so back-to-back ties alternate
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_fwd  <= 1'b0;
            gnt_inj  <= 1'b0;
            last_inj <= 1'b1;
        end else begin
            if (win_fwd)
                gnt_fwd <= 1'b1;
            else if (fwd_load && head_last)
                gnt_fwd <= 1'b0;
            if (inj_load && local_in.last)
                gnt_inj <= 1'b0;
            else if (win_inj)
                gnt_inj <= 1'b1;
            if (tie)
                last_inj <= win_inj;
        end
    end

    // routing FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // routing FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty && head_local) state_nxt = TO_LOCAL;
                else if (win_fwd)         state_nxt = TO_RING;
            end
            TO_LOCAL: if (lo_xfer && head_last)  state_nxt = IDLE;
            TO_RING:  if (fwd_load && head_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // routing FSM: outputs
    always_comb begin
        local_out.valid = 1'b0;
        fwd_load        = 1'b0;
        unique case (state)
            TO_LOCAL: local_out.valid = !rst && !empty;
            TO_RING:  fwd_load        = !empty && load_ok;
            default:  ;
        endcase
    end

    assign local_out.last = head_last;
    assign local_out.data = head[15:0];
    assign lo_xfer        = local_out.valid && local_out.ready;
    assign pop            = fwd_load || lo_xfer;

    // ring_out register; at most one of fwd_load/inj_load per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (load_ok) begin
            out_valid <= fwd_load || inj_load;
            out_flit  <= fwd_load ? head : {local_in.last, local_in.data};
        end
    end

    assign ring_out.valid = out_valid && !rst;
    assign ring_out.last  = out_flit[16];
    assign ring_out.data  = out_flit[15:0];
endmodule
